// File: rtl/sriov_pkg.sv
// Shared types and helpers for the SR-IOV VF enable/disable sequencer.
package sriov_pkg;

   localparam int NUMVFS_W = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      INIT     = 3'd1,
      SETTLE   = 3'd2,
      ACTIVE   = 3'd3,
      DRAIN    = 3'd4,
      TEARDOWN = 3'd5
   } seq_state_e;

   // NumVFs beyond what the PF can back is silently capped.
   function automatic logic [NUMVFS_W-1:0] clamp_numvfs(input logic [NUMVFS_W-1:0] n,
                                                        input int max_vfs);
      logic [NUMVFS_W-1:0] m;
      m = NUMVFS_W'(max_vfs);
      return (n > m) ? m : n;
   endfunction

endpackage

// File: rtl/sriov_vf_walker.sv
// Walks VF indices 0..count-1 over a valid/ready handshake; stop ends the walk
// at the next accepted index and accepted reports how many indices got through.
module sriov_vf_walker #(
   parameter int MAX_VFS  = 64,
   parameter int VF_IDX_W = $clog2(MAX_VFS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [VF_IDX_W:0]   count,
   input  logic                stop,
   output logic                valid,
   output logic [VF_IDX_W-1:0] idx,
   input  logic                ready,
   output logic                done,
   output logic [VF_IDX_W:0]   accepted
);

   localparam logic [VF_IDX_W:0]   CNT_ONE = 1;
   localparam logic [VF_IDX_W-1:0] IDX_ONE = 1;

   logic [VF_IDX_W:0] count_q;
   logic              last_idx;

   assign last_idx = ({1'b0, idx} == (count_q - CNT_ONE));
   assign done     = valid && ready && (last_idx || stop);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid    <= 1'b0;
         idx      <= '0;
         count_q  <= '0;
         accepted <= '0;
      end else if (start) begin
         count_q  <= count;
         idx      <= '0;
         accepted <= '0;
         valid    <= (count != '0);
      end else if (valid && ready) begin
         accepted <= {1'b0, idx} + CNT_ONE;
         if (last_idx || stop) begin
            valid <= 1'b0;
         end else begin
            idx <= idx + IDX_ONE;
         end
      end
   end

endmodule

// File: rtl/sriov_vf_enable_seq.sv
// SR-IOV VF bring-up/teardown sequencer driven by the VF Enable level:
// init walk, CRS settle window, active, non-posted drain, reset walk.
module sriov_vf_enable_seq
   import sriov_pkg::*;
#(
   parameter int MAX_VFS       = 64,
   parameter int SETTLE_CYCLES = 1024,
   parameter int DRAIN_TIMEOUT = 4096,
   parameter int CNT_W         = 16,
   parameter int VF_IDX_W      = $clog2(MAX_VFS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                vf_enable,
   input  logic [15:0]         num_vfs,
   input  logic                has_outstanding_nonposted_requests,
   output logic                vf_init_valid,
   output logic [VF_IDX_W-1:0] vf_init_idx,
   input  logic                vf_init_ready,
   output logic                vf_reset_valid,
   output logic [VF_IDX_W-1:0] vf_reset_idx,
   input  logic                vf_reset_ready,
   output logic                vf_cfg_retry,
   output logic                vf_active,
   output logic                busy,
   output logic                drain_timeout_err,
   output logic [2:0]          seq_state
);

   localparam logic [CNT_W-1:0] CNT_ONE     = 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);

   seq_state_e          state;
   logic [CNT_W-1:0]    cnt;
   logic                init_start;
   logic                init_done;
   logic [VF_IDX_W:0]   init_acc;
   logic                reset_start;
   logic                reset_done;
   logic [VF_IDX_W:0]   reset_acc;
   logic                drain_exit;

   assign init_start  = (state == IDLE) && vf_enable;
   assign drain_exit  = !has_outstanding_nonposted_requests || (cnt == DRAIN_LAST);
   assign reset_start = (state == DRAIN) && drain_exit;

   // The init walk's accepted count defines how many VFs need a reset.
   sriov_vf_walker #(.MAX_VFS(MAX_VFS), .VF_IDX_W(VF_IDX_W)) u_init_walker (
      .clk      (clk),
      .rst      (rst),
      .start    (init_start),
      .count    ((VF_IDX_W+1)'(clamp_numvfs(num_vfs, MAX_VFS))),
      .stop     (!vf_enable),
      .valid    (vf_init_valid),
      .idx      (vf_init_idx),
      .ready    (vf_init_ready),
      .done     (init_done),
      .accepted (init_acc)
   );

   sriov_vf_walker #(.MAX_VFS(MAX_VFS), .VF_IDX_W(VF_IDX_W)) u_reset_walker (
      .clk      (clk),
      .rst      (rst),
      .start    (reset_start),
      .count    (init_acc),
      .stop     (1'b0),
      .valid    (vf_reset_valid),
      .idx      (vf_reset_idx),
      .ready    (vf_reset_ready),
      .done     (reset_done),
      .accepted (reset_acc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         cnt               <= '0;
         drain_timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (vf_enable) begin
                  drain_timeout_err <= 1'b0;
                  cnt               <= '0;
                  state             <= (num_vfs != '0) ? INIT : SETTLE;
               end
            end
            INIT: begin
               if (init_done) begin
                  cnt   <= '0;
                  state <= vf_enable ? SETTLE : DRAIN;
               end
            end
            SETTLE: begin
               if (!vf_enable) begin
                  cnt   <= '0;
                  state <= DRAIN;
               end else if (cnt == SETTLE_LAST) begin
                  state <= ACTIVE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            ACTIVE: begin
               if (!vf_enable) begin
                  cnt   <= '0;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // A drain that clears on the final cycle counts as clean.
               if (!has_outstanding_nonposted_requests) begin
                  state <= TEARDOWN;
               end else if (cnt == DRAIN_LAST) begin
                  drain_timeout_err <= 1'b1;
                  state             <= TEARDOWN;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            TEARDOWN: begin
               if (reset_done || (reset_acc == init_acc)) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign seq_state    = state;
   assign vf_cfg_retry = (state == INIT) || (state == SETTLE);
   assign vf_active    = (state == ACTIVE);
   assign busy         = (state == INIT) || (state == SETTLE) ||
                         (state == DRAIN) || (state == TEARDOWN);

endmodule
